// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// The clear FSM encoding, default sizes and packed-bus slicing live here.
package regfile_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StClear = 2'b01,
    StDone  = 2'b10
  } clr_state_e;

  localparam int unsigned DefDataW  = 32;
  localparam int unsigned DefDepth  = 32;

  // Upper bounds for the generic slice helper; checked at elaboration by the top.
  localparam int unsigned MaxBusW   = 4096;
  localparam int unsigned MaxSliceW = 64;

  function automatic logic [MaxSliceW-1:0] get_slice(input logic [MaxBusW-1:0] bus,
                                                     input int unsigned        idx,
                                                     input int unsigned        w);
    logic [MaxSliceW-1:0] mask;
    mask = (w >= MaxSliceW) ? '1 : ((MaxSliceW'(1) << w) - MaxSliceW'(1));
    return MaxSliceW'(bus >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port match for one register index: highest-numbered enabled port wins.
// Shared by the read bypass and the storage write path so both use one priority rule.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_WR = 2
) (
  input  logic [ADDR_W-1:0]        idx_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_num_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_din_i,
  output logic                     hit_o,
  output logic [DATA_W-1:0]        data_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      if (wr_en_i[p] && (ADDR_W'(get_slice(MaxBusW'(wr_num_i), p, ADDR_W)) == idx_i)) begin
        hit_o  = 1'b1;
        data_o = DATA_W'(get_slice(MaxBusW'(wr_din_i), p, DATA_W));
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass and a background clear sweep.
// Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_RD*ADDR_W-1:0] rd_num_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_num_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_din_i,
  input  logic                     clr_req_i,
  output logic                     clr_busy_o,
  output logic                     clr_done_o
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("regfile_mp: DEPTH must be a power of two and at least 2");
  end
  if (DATA_W > MaxSliceW || NUM_RD * ADDR_W > MaxBusW || NUM_WR * DATA_W > MaxBusW) begin
    : g_bad_width
    $error("regfile_mp: port bus exceeds slice helper limits");
  end

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_hit  [DEPTH];
  logic [DATA_W-1:0] wr_data [DEPTH];

  // Clear FSM: state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Clear FSM: next state. Index wraps to 0 after DEPTH-1 since DEPTH is a power of two.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req_i) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      StClear: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == ADDR_W'(DEPTH - 1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Clear FSM: outputs.
  always_comb begin
    clr_busy_o = (state_q == StClear);
    clr_done_o = (state_q == StDone);
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_wr
    regfile_wr_arb #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NUM_WR(NUM_WR)
    ) u_wr_arb (
      .idx_i   (ADDR_W'(e)),
      .wr_en_i (wr_en_i),
      .wr_num_i(wr_num_i),
      .wr_din_i(wr_din_i),
      .hit_o   (wr_hit[e]),
      .data_o  (wr_data[e])
    );
  end

  // Functional writes override the sweep on the entry being cleared.
  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      mem_d[e] = mem_q[e];
      if (state_q == StClear && idx_q == ADDR_W'(e)) mem_d[e] = '0;
      if (wr_hit[e]) mem_d[e] = wr_data[e];
    end
`ifdef REGFILE_ZERO_REG_EN
    mem_d[0] = '0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned e = 0; e < DEPTH; e++) mem_q[e] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_byp;

    assign rd_idx = ADDR_W'(get_slice(MaxBusW'(rd_num_i), k, ADDR_W));

    regfile_wr_arb #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NUM_WR(NUM_WR)
    ) u_rd_arb (
      .idx_i   (rd_idx),
      .wr_en_i (wr_en_i),
      .wr_num_i(wr_num_i),
      .wr_din_i(wr_din_i),
      .hit_o   (rd_hit),
      .data_o  (rd_byp)
    );

`ifdef REGFILE_ZERO_REG_EN
    assign rd_data_o[k*DATA_W +: DATA_W] = (rd_idx == '0) ? '0 :
                                           rd_hit ? rd_byp : mem_q[rd_idx];
`else
    assign rd_data_o[k*DATA_W +: DATA_W] = rd_hit ? rd_byp : mem_q[rd_idx];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp against an array-based model, plus directed literal checks.
module tb_regfile_mp;
  localparam int unsigned DW = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [DW-1:0] R0Expect = 32'h0;
`else
  localparam logic [DW-1:0] R0Expect = 32'h55;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR*AW-1:0] rd_num;
  logic [NR*DW-1:0] rd_data;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_num;
  logic [NW*DW-1:0] wr_din;
  logic             clr_req, clr_busy, clr_done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [D];
  bit            sw_active = 1'b0;
  bit            sw_done   = 1'b0;
  int            sw_ptr    = 0;
  bit            cmp_en    = 1'b0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W(DW),
    .DEPTH (D),
    .ADDR_W(AW),
    .NUM_RD(NR),
    .NUM_WR(NW)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rd_num_i  (rd_num),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_num_i  (wr_num),
    .wr_din_i  (wr_din),
    .clr_req_i (clr_req),
    .clr_busy_o(clr_busy),
    .clr_done_o(clr_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int k);
    int a;
    logic [DW-1:0] v;
    a = int'(rd_num[k*AW +: AW]);
    v = model[a];
    for (int p = 0; p < NW; p++)
      if (wr_en[p] && int'(wr_num[p*AW +: AW]) == a) v = wr_din[p*DW +: DW];
`ifdef REGFILE_ZERO_REG_EN
    if (a == 0) v = '0;
`endif
    return v;
  endfunction

  // Model of one rising edge, using the inputs held across that edge.
  task automatic model_update();
    if (!rst_n) begin
      for (int i = 0; i < D; i++) model[i] = '0;
      sw_active = 1'b0;
      sw_done   = 1'b0;
      sw_ptr    = 0;
    end else begin
      if (sw_active) model[sw_ptr] = '0;
      for (int p = 0; p < NW; p++) begin
        if (wr_en[p]) begin
`ifdef REGFILE_ZERO_REG_EN
          if (wr_num[p*AW +: AW] != '0) model[int'(wr_num[p*AW +: AW])] = wr_din[p*DW +: DW];
`else
          model[int'(wr_num[p*AW +: AW])] = wr_din[p*DW +: DW];
`endif
        end
      end
      if (sw_active) begin
        sw_ptr++;
        if (sw_ptr == D) begin
          sw_active = 1'b0;
          sw_done   = 1'b1;
        end
      end else if (sw_done) begin
        sw_done = 1'b0;
      end else if (clr_req) begin
        sw_active = 1'b1;
        sw_ptr    = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NR; k++) chk("rd_data", 64'(rd_data[k*DW +: DW]), 64'(exp_rd(k)));
      chk("clr_busy", 64'(clr_busy), 64'(sw_active));
      chk("clr_done", 64'(clr_done), 64'(sw_done));
    end
  end

  initial begin
    int busy_cnt;
    int done_cnt;
    for (int i = 0; i < D; i++) model[i] = '0;
    rst_n = 1'b0; rd_num = '0; wr_en = '0; wr_num = '0; wr_din = '0; clr_req = 1'b0;
    tick();
    tick();
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Reset state on every index, both ports.
    for (int a = 0; a < D; a++) begin
      rd_num = {AW'(a), AW'(D - 1 - a)};
      #2;
      chk("reset_rd0", 64'(rd_data[DW-1:0]), 64'h0);
      chk("reset_rd1", 64'(rd_data[2*DW-1:DW]), 64'h0);
      tick();
    end
    chk("reset_busy", 64'(clr_busy), 64'h0);
    chk("reset_done", 64'(clr_done), 64'h0);

    // Same-cycle bypass on r5.
    wr_en = 2'b01; wr_num = {AW'(0), AW'(5)}; wr_din = {32'h0, 32'hDEADBEEF};
    rd_num = {AW'(0), AW'(5)};
    #2 chk("bypass_r5", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
    tick();
    wr_en = '0;
    #2 chk("stored_r5", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
    tick();

    // Port priority on r7.
    wr_en = 2'b11; wr_num = {AW'(7), AW'(7)}; wr_din = {32'h22, 32'h11};
    rd_num = {AW'(7), AW'(7)};
    #2 chk("prio_byp_r7", 64'(rd_data[DW-1:0]), 64'h22);
    tick();
    wr_en = '0;
    #2 chk("prio_st_r7", 64'(rd_data[2*DW-1:DW]), 64'h22);
    tick();

    // Entry 0 write with same-cycle read.
    wr_en = 2'b01; wr_num = '0; wr_din = {32'h0, 32'h55}; rd_num = '0;
    #2 chk("r0_byp", 64'(rd_data[DW-1:0]), 64'(R0Expect));
    tick();
    wr_en = '0;
    #2 chk("r0_st", 64'(rd_data[DW-1:0]), 64'(R0Expect));
    tick();

    // Fill with index+1, sweep, and collide a write with the sweep on r31.
    for (int i = 0; i < D; i++) begin
      wr_en = 2'b10; wr_num = {AW'(i), AW'(0)}; wr_din = {32'(i + 1), 32'h0};
      tick();
    end
    wr_en = '0;
    clr_req = 1'b1;
    tick();
    busy_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      clr_req = (n == 5 || n == 32);
      if (n == 31) begin
        wr_en = 2'b01; wr_num = {AW'(0), AW'(31)}; wr_din = {32'h0, 32'hABCD};
      end else begin
        wr_en = '0;
      end
      #2;
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      tick();
    end
    clr_req = 1'b0; wr_en = '0;
    chk("sweep_busy_cycles", 64'(busy_cnt), 64'd32);
    chk("sweep_done_pulses", 64'(done_cnt), 64'd1);
    for (int a = 0; a < D; a++) begin
      rd_num = {AW'(a), AW'(a)};
      #2 chk("post_sweep", 64'(rd_data[DW-1:0]), (a == 31) ? 64'hABCD : 64'h0);
      tick();
    end

    // Reset mid-sweep at index 10.
    wr_en = 2'b01; wr_num = {AW'(0), AW'(3)}; wr_din = {32'h0, 32'h1234};
    tick();
    wr_en = '0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      rd_num = {AW'(n), AW'(n + 1)};
      #2;
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (n < 32) chk("abort_zero", 64'(rd_data[DW-1:0]), 64'h0);
      tick();
    end
    chk("abort_busy", 64'(busy_cnt), 64'd0);
    chk("abort_done", 64'(done_cnt), 64'd0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    #2 chk("restart_busy", 64'(clr_busy), 64'h1);
    repeat (34) tick();

    // Randomised traffic with collisions, sweeps and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      clr_req = ($urandom_range(0, 39) == 0);
      rd_num  = (NR * AW)'($urandom);
      wr_en   = NW'($urandom);
      for (int p = 0; p < NW; p++) begin
        wr_num[p*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3))
                                                         : AW'($urandom);
        wr_din[p*DW +: DW] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) rd_num[AW-1:0] = wr_num[AW-1:0];
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
